// File: rtl/serial_cmp_ctrl.sv
// Multi-cycle MSB-first magnitude comparator: CHUNK bits per RUN cycle through a cascade of
// 1-bit less/equal cells. Define CMP_EARLY_EXIT_EN to finish as soon as the operands differ.
module serial_cmp_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_less,
    output logic             o_equal
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("serial_cmp_ctrl: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             run_less_q, run_less_d;
    logic             run_equal_q, run_equal_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    // Operands are shifted left each RUN cycle, so the active chunk is always the top CHUNK bits.
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   lt_chain, eq_chain;

    assign a_chunk     = a_sh_q[WIDTH-1 -: CHUNK];
    assign b_chunk     = b_sh_q[WIDTH-1 -: CHUNK];
    assign lt_chain[0] = run_less_q;
    assign eq_chain[0] = run_equal_q;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
            logic a_bit, b_bit, swap, ca, cb;
            assign a_bit = a_chunk[CHUNK-1-gi];
            assign b_bit = b_chunk[CHUNK-1-gi];
            // Sign bit of a two's-complement operand carries inverted weight: swap a/b there.
            assign swap  = signed_q && (idx_q == '0) && (gi == 0);
            assign ca    = swap ? b_bit : a_bit;
            assign cb    = swap ? a_bit : b_bit;
            assign lt_chain[gi+1] = lt_chain[gi] | (eq_chain[gi] & ~ca & cb);
            assign eq_chain[gi+1] = eq_chain[gi] & ~(ca ^ cb);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        signed_d    = signed_q;
        idx_d       = idx_q;
        run_less_d  = run_less_q;
        run_equal_d = run_equal_q;
        less_d      = less_q;
        equal_d     = equal_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    a_sh_d      = i_a;
                    b_sh_d      = i_b;
                    signed_d    = i_signed;
                    idx_d       = '0;
                    run_less_d  = 1'b0;
                    run_equal_d = 1'b1;
                    less_d      = 1'b0;
                    equal_d     = 1'b0;
                    state_d     = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                run_less_d  = lt_chain[CHUNK];
                run_equal_d = eq_chain[CHUNK];
                a_sh_d      = a_sh_q << CHUNK;
                b_sh_d      = b_sh_q << CHUNK;
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end
                // A differing chunk already fixes the result; remaining chunks cannot change it.
                if ((idx_q == LAST_IDX) || (EARLY_EXIT && !eq_chain[CHUNK])) begin
                    less_d  = lt_chain[CHUNK];
                    equal_d = eq_chain[CHUNK];
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            signed_q    <= 1'b0;
            idx_q       <= '0;
            run_less_q  <= 1'b0;
            run_equal_q <= 1'b0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            signed_q    <= signed_d;
            idx_q       <= idx_d;
            run_less_q  <= run_less_d;
            run_equal_q <= run_equal_d;
            less_q      <= less_d;
            equal_q     <= equal_d;
        end
    end

    assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign o_busy  = (state_q == S_RUN);
    assign o_done  = (state_q == S_DONE);
    assign o_less  = less_q;
    assign o_equal = equal_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl (32-bit, 4-bit chunks) against an arithmetic reference.
module tb_serial_cmp_ctrl;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             i_reset = 1'b0;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] i_a = '0;
    logic [WIDTH-1:0] i_b = '0;
    logic             i_signed = 1'b0;
    logic             o_ready, o_busy, o_done, o_less, o_equal;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_cmp_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_signed (i_signed),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_less   (o_less),
        .o_equal  (o_equal)
    );

    always #5 clk = ~clk;

    function automatic logic ref_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic s);
        if (s) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Edges from start assertion to o_done: one accept edge, RUN chunks, then DONE.
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
        for (int k = 0; k < N; k++) begin
            if (((a >> (WIDTH - CHUNK * (k + 1))) & 32'hF) != ((b >> (WIDTH - CHUNK * (k + 1))) & 32'hF))
                return k + 2;
        end
`endif
        return N + 1;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          output int lat, output logic lt, output logic eq, output bit timeout);
        @(negedge clk);
        i_a = a; i_b = b; i_signed = s; i_start = 1'b1;
        lat = 0;
        timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            i_start = 1'b0;
            lat++;
            if (o_done) begin
                timeout = 1'b0;
                break;
            end
        end
        lt = o_less;
        eq = o_equal;
    endtask

    task automatic check_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s);
        int lat; logic lt, eq; bit to;
        logic exp_lt, exp_eq; int exp_l;
        exp_lt = ref_less(a, b, s);
        exp_eq = (a == b);
        exp_l  = ref_lat(a, b);
        run_op(a, b, s, lat, lt, eq, to);
        tests_run++;
        if (to || lat !== exp_l || lt !== exp_lt || eq !== exp_eq) begin
            tests_failed++;
            $display("FAIL %s a=%h b=%h s=%0d: got lat=%0d less=%0d equal=%0d timeout=%0d, expected lat=%0d less=%0d equal=%0d",
                     name, a, b, s, lat, lt, eq, to, exp_l, exp_lt, exp_eq);
        end else begin
            $display("[TB] %s a=%h b=%h s=%0d lat=%0d less=%0d equal=%0d ok", name, a, b, s, lat, lt, eq);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        i_reset = 1'b1; i_start = 1'b1; i_a = 32'h1; i_b = 32'h2;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({o_ready, o_busy, o_done, o_less, o_equal} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset: ready/busy/done/less/equal=%b expected 10000",
                     {o_ready, o_busy, o_done, o_less, o_equal});
        end else $display("[TB] reset outputs ok");
        i_reset = 1'b0; i_start = 1'b0;
    endtask

    task automatic test_unsigned();
        check_op("unsigned_lt", 32'h0000_0005, 32'h0000_0007, 1'b0);
        check_op("unsigned_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        check_op("unsigned_gt", 32'hFFFF_0000, 32'h0FFF_FFFF, 1'b0);
        // Result must stay held in IDLE after the DONE cycle.
        repeat (2) @(negedge clk);
        tests_run++;
        if (o_less !== 1'b0 || o_equal !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_idle: less=%0d equal=%0d ready=%0d done=%0d expected 0 0 1 0",
                     o_less, o_equal, o_ready, o_done);
        end else $display("[TB] hold_idle ok");
    endtask

    task automatic test_signed();
        check_op("signed_neg_lt", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check_op("unsigned_big",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check_op("signed_pos_gt", 32'h0000_0001, 32'h8000_0000, 1'b1);
        check_op("signed_negs",   32'h8000_0000, 32'hFFFF_FFFE, 1'b1);
    endtask

    task automatic test_early_exit();
        check_op("msb_differs", 32'h8000_0000, 32'h0000_0000, 1'b0);
        check_op("lsb_differs", 32'h1234_5670, 32'h1234_5671, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, WIDTH - 1));
                2: b = $urandom;
                default: b = {~a[WIDTH-1], a[WIDTH-2:0]};
            endcase
            check_op("random", a, b, s);
        end
    endtask

    task automatic test_hold_start();
        logic [WIDTH-1:0] a0, b0, a1, b1;
        logic s0, s1, exp_lt, exp_eq;
        int pulses, first_lat, second_lat, cyc;
        bit after_first;
        a0 = $urandom; b0 = $urandom; s0 = 1'b1;
        pulses = 0; first_lat = 0; second_lat = 0; cyc = 0; after_first = 1'b0;
        a1 = '0; b1 = '0; s1 = 1'b0;
        @(negedge clk);
        i_a = a0; i_b = b0; i_signed = s0; i_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (o_done) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat = cyc;
                    exp_lt = ref_less(a0, b0, s0);
                    exp_eq = (a0 == b0);
                    tests_run++;
                    if (o_less !== exp_lt || o_equal !== exp_eq) begin
                        tests_failed++;
                        $display("FAIL hold_start_first: less=%0d equal=%0d expected %0d %0d",
                                 o_less, o_equal, exp_lt, exp_eq);
                    end else $display("[TB] hold_start_first a=%h b=%h ok", a0, b0);
                    // Operands driven now are taken by the back-to-back accept at the next edge.
                    a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1));
                    i_a = a1; i_b = b1; i_signed = s1;
                    after_first = 1'b1;
                    continue;
                end else begin
                    second_lat = cyc - first_lat;
                    exp_lt = ref_less(a1, b1, s1);
                    exp_eq = (a1 == b1);
                    tests_run++;
                    if (o_less !== exp_lt || o_equal !== exp_eq) begin
                        tests_failed++;
                        $display("FAIL hold_start_second: less=%0d equal=%0d expected %0d %0d",
                                 o_less, o_equal, exp_lt, exp_eq);
                    end else $display("[TB] hold_start_second a=%h b=%h ok", a1, b1);
                    break;
                end
            end
            if (after_first) begin
                i_start = 1'b0;
                after_first = 1'b0;
            end
            i_a = $urandom; i_b = $urandom; i_signed = 1'($urandom_range(0, 1));
        end
        i_start = 1'b0;
        tests_run++;
        if (pulses != 2 || first_lat != ref_lat(a0, b0) || second_lat != ref_lat(a1, b1)) begin
            tests_failed++;
            $display("FAIL hold_start_timing: pulses=%0d lat1=%0d lat2=%0d expected 2 %0d %0d",
                     pulses, first_lat, second_lat, ref_lat(a0, b0), ref_lat(a1, b1));
        end else $display("[TB] hold_start_timing ok");
    endtask

    task automatic test_back_to_back();
        int lat; logic lt, eq; bit to;
        run_op(32'h0000_0003, 32'h0000_0009, 1'b0, lat, lt, eq, to);
        // Still in the DONE cycle: issue the next op immediately.
        i_a = 32'h7000_0000; i_b = 32'h7000_0000; i_signed = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        tests_run++;
        if (to || o_done !== 1'b0 || o_busy !== 1'b1 || o_less !== 1'b0 || o_equal !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back_accept: timeout=%0d done=%0d busy=%0d less=%0d equal=%0d expected 0 0 1 0 0",
                     to, o_done, o_busy, o_less, o_equal);
        end else $display("[TB] back_to_back_accept ok");
        lat = 1;
        to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            if (o_done) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to || lat != N + 1 || o_less !== 1'b0 || o_equal !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back_second: lat=%0d less=%0d equal=%0d expected %0d 0 1",
                     lat, o_less, o_equal, N + 1);
        end else $display("[TB] back_to_back_second lat=%0d ok", lat);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        i_a = 32'h0000_0001; i_b = 32'h0000_0002; i_signed = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b1; i_start = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({o_ready, o_busy, o_done, o_less, o_equal} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_mid_run: ready/busy/done/less/equal=%b expected 10000",
                     {o_ready, o_busy, o_done, o_less, o_equal});
        end else $display("[TB] reset_mid_run ok");
        i_reset = 1'b0; i_start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            if (o_done || o_busy) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_run_quiet: busy/done cycles=%0d expected 0", pulses);
        end else $display("[TB] reset_mid_run_quiet ok");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_early_exit();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
